// File: rtl/decimal_pkg.sv
// Shared constants and state encoding for decimal entry and the scan-tube display path.
package decimal_pkg;

   localparam int              DEC_MAX_DIGITS = 3;
   localparam int              DEC_OUT_W      = 10;
   localparam logic [3:0]      BCD_MAX        = 4'd9;

   typedef enum logic [1:0] {
      ENTRY = 2'd0,
      CONV  = 2'd1,
      DONE  = 2'd2
   } dec_state_e;

   // Digit position 1 is the most recent entry; position 0 has no digit.
   function automatic logic [3:0] bcd_nibble(input logic [11:0] digits, input logic [1:0] pos);
      case (pos)
         2'd1:    return digits[3:0];
         2'd2:    return digits[7:4];
         2'd3:    return digits[11:8];
         default: return 4'h0;
      endcase
   endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// One Horner step: next_acc = acc*10 + digit, built from shifts and adds only.
module bcd_mac_step
   import decimal_pkg::*;
#(
   parameter int OUT_W = DEC_OUT_W
) (
   input  logic [OUT_W-1:0] acc,
   input  logic [3:0]       digit,
   output logic [OUT_W-1:0] next_acc
);

   logic [OUT_W-1:0] acc_x8;
   logic [OUT_W-1:0] acc_x2;

   assign acc_x8   = acc << 3;
   assign acc_x2   = acc << 1;
   assign next_acc = acc_x8 + acc_x2 + {{(OUT_W-4){1'b0}}, digit};

endmodule

// File: rtl/decimal_entry_assembler.sv
// Collects up to three BCD digits and converts them to binary on commit.
// Optional DECIMAL_ENTRY_AUTO_COMMIT_EN: a full buffer starts conversion by itself.
module decimal_entry_assembler
   import decimal_pkg::*;
#(
   parameter int MAX_DIGITS = DEC_MAX_DIGITS,
   parameter int OUT_W      = DEC_OUT_W
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic [3:0]       DigitIn,
   input  logic             DigitValid,
   input  logic             Backspace,
   input  logic             Clear,
   input  logic             Commit,
   output logic [11:0]      Digits,
   output logic [1:0]       Count,
   output logic             Busy,
   output logic             Err,
   output logic [OUT_W-1:0] Value,
   output logic             ValueValid
);

   localparam logic [1:0] FULL = 2'(MAX_DIGITS);

   dec_state_e       state_q, state_d;
   logic [11:0]      digits_q, digits_d;
   logic [1:0]       count_q, count_d;
   logic [1:0]       idx_q, idx_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] value_q, value_d;
   logic             value_valid_q, value_valid_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             commit_eff;
   logic [OUT_W-1:0] next_acc;

`ifdef DECIMAL_ENTRY_AUTO_COMMIT_EN
   logic auto_q, auto_d;
   assign commit_eff = Commit | auto_q;
`else
   assign commit_eff = Commit;
`endif

   bcd_mac_step #(.OUT_W(OUT_W)) u_mac (
      .acc      (acc_q),
      .digit    (bcd_nibble(digits_q, idx_q)),
      .next_acc (next_acc)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d       = state_q;
      digits_d      = digits_q;
      count_d       = count_q;
      idx_d         = idx_q;
      acc_d         = acc_q;
      value_d       = value_q;
      value_valid_d = 1'b0;
      err_d         = 1'b0;
`ifdef DECIMAL_ENTRY_AUTO_COMMIT_EN
      auto_d        = 1'b0;
`endif
      case (state_q)
         ENTRY: begin
            if (Clear) begin
               digits_d = '0;
               count_d  = '0;
            end else if (Backspace) begin
               if (count_q != 2'd0) begin
                  digits_d = {4'h0, digits_q[11:4]};
                  count_d  = count_q - 2'd1;
               end
            end else if (commit_eff) begin
               acc_d   = '0;
               idx_d   = count_q;
               state_d = CONV;
            end else if (DigitValid) begin
               if (DigitIn > BCD_MAX || count_q == FULL) begin
                  err_d = 1'b1;
               end else begin
                  digits_d = {digits_q[7:0], DigitIn};
                  count_d  = count_q + 2'd1;
`ifdef DECIMAL_ENTRY_AUTO_COMMIT_EN
                  auto_d   = (count_q == FULL - 2'd1);
`endif
               end
            end
         end
         CONV: begin
            if (idx_q == 2'd0) begin
               value_d       = acc_q;
               value_valid_d = 1'b1;
               state_d       = DONE;
            end else begin
               acc_d = next_acc;
               idx_d = idx_q - 2'd1;
            end
         end
         DONE: begin
            digits_d = '0;
            count_d  = '0;
            state_d  = ENTRY;
         end
         default: state_d = ENTRY;
      endcase
      busy_d = (state_d != ENTRY);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q       <= ENTRY;
         digits_q      <= '0;
         count_q       <= '0;
         idx_q         <= '0;
         acc_q         <= '0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         digits_q      <= digits_d;
         count_q       <= count_d;
         idx_q         <= idx_d;
         acc_q         <= acc_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         err_q         <= err_d;
         busy_q        <= busy_d;
      end
   end

`ifdef DECIMAL_ENTRY_AUTO_COMMIT_EN
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) auto_q <= 1'b0;
      else        auto_q <= auto_d;
   end
`endif

   assign Digits     = digits_q;
   assign Count      = count_q;
   assign Busy       = busy_q;
   assign Err        = err_q;
   assign Value      = value_q;
   assign ValueValid = value_valid_q;

endmodule
